// File: rtl/ahb_sram_excl_resp.sv
// AHB-Lite/AHB5 word-organised SRAM responder with wait states, error responses and an optional exclusive monitor.
// Latency: data phase completes WAIT_STATES+1 cycles after address accept (errors add one ERR1 cycle).
// Backpressure: hready low during wait/ERR1 cycles; a new address is accepted in IDLE/DONE/ERR2 cycles.
// Optional feature macro: AHB_SRAM_EXCL_MONITOR_EN (single-reservation exclusive monitor driving hexokay).
module ahb_sram_excl_resp #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic              hexcl,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hmastlock,
  input  logic [W_DATA-1:0] hwdata,
  output logic              hready,
  output logic              hresp,
  output logic              hexokay,
  output logic [W_DATA-1:0] hrdata
);

  localparam int W_IDX = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;

  // Registered address-phase fields for the transfer now in its data phase
  logic [W_IDX-1:0]  a_idx;
  logic [1:0]        a_lane;
  logic [1:0]        a_size;
  logic              a_write;
  logic              a_err;

  logic              addr_err;
  logic [3:0]        byte_en;
  logic              excl_pass;
  logic              excl_okay;
  logic              wr_commit;

  logic [W_DATA-1:0] mem [DEPTH];

`ifdef AHB_SRAM_EXCL_MONITOR_EN
  logic              a_excl;
  logic              resv_vld;
  logic [W_IDX-1:0]  resv_idx;
  logic              resv_hit;
`endif

  // Classify the incoming address: bad size, misalignment, or word index beyond the array
  always_comb begin
    addr_err = 1'b0;
    case (hsize)
      3'd0:    addr_err = 1'b0;
      3'd1:    addr_err = haddr[0];
      3'd2:    addr_err = |haddr[1:0];
      default: addr_err = 1'b1;
    endcase
    if ((haddr >> (W_IDX + 2)) != '0) addr_err = 1'b1;
  end

  // Capture address-phase fields whenever a transfer is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      a_idx   <= '0;
      a_lane  <= '0;
      a_size  <= '0;
      a_write <= 1'b0;
      a_err   <= 1'b0;
`ifdef AHB_SRAM_EXCL_MONITOR_EN
      a_excl  <= 1'b0;
`endif
    end else if (hready && htrans[1]) begin
      a_idx   <= haddr[W_IDX+1:2];
      a_lane  <= haddr[1:0];
      a_size  <= hsize[1:0];
      a_write <= hwrite;
      a_err   <= addr_err;
`ifdef AHB_SRAM_EXCL_MONITOR_EN
      a_excl  <= hexcl;
`endif
    end
  end

  // Data-phase state register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and handshake outputs; IDLE/DONE/ERR2 are the cycles that can accept an address
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    hready       = 1'b1;
    hresp        = 1'b0;
    case (state)
      S_WAIT: begin
        hready = 1'b0;
        if (wait_cnt == 4'd0) state_nxt = a_err ? S_ERR1 : S_DONE;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      default: begin
        hresp = (state == S_ERR2);
        if (htrans[1]) begin
          if (WAIT_STATES != 0) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = addr_err ? S_ERR1 : S_DONE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Byte lanes touched by the registered size and low address bits
  always_comb begin
    byte_en = 4'b0000;
    case (a_size)
      2'd0:    byte_en = 4'b0001 << a_lane;
      2'd1:    byte_en = a_lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_EXCL_MONITOR_EN
  assign resv_hit  = resv_vld && (resv_idx == a_idx);
  assign excl_pass = !a_excl || resv_hit;
  assign excl_okay = (state == S_DONE) && a_excl && (a_write ? resv_hit : 1'b1);

  // Reservation: set by OKAY exclusive reads, dropped by any committed write to the reserved word
  always_ff @(posedge clk) begin
    if (rst) begin
      resv_vld <= 1'b0;
      resv_idx <= '0;
    end else if (state == S_DONE) begin
      if (a_excl && !a_write) begin
        resv_vld <= 1'b1;
        resv_idx <= a_idx;
      end else if (a_write && resv_hit) begin
        resv_vld <= 1'b0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};
`else
  assign excl_pass = 1'b1;
  assign excl_okay = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], hexcl};
`endif

  assign wr_commit = !rst && (state == S_DONE) && a_write && excl_pass;

  // Commit write data at the edge that ends the DONE cycle; memory has no reset
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[a_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Read data and exclusive status are only presented in the OKAY completion cycle
  always_comb begin
    hrdata  = '0;
    hexokay = 1'b0;
    if (state == S_DONE) begin
      hrdata  = mem[a_idx];
      hexokay = excl_okay;
    end
  end

endmodule

// File: tb/tb_ahb_sram_excl_resp.sv
// Randomised and directed bench for ahb_sram_excl_resp against a transfer-level reference model.
// Two responders (0 and 2 wait states) share the stimulus; only the selected one sees live transfers.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge or just after the rising edge.
module tb_ahb_sram_excl_resp;

  localparam int DEPTH = 64;

`ifdef AHB_SRAM_EXCL_MONITOR_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif

  typedef struct {
    bit          wr;
    bit          ex;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hexcl = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  bit          sel = 1'b0;

  logic [1:0]  htrans0, htrans2;
  logic        hready0, hresp0, hexokay0, hready2, hresp2, hexokay2;
  logic [31:0] hrdata0, hrdata2;
  logic        hready, hresp, hexokay;
  logic [31:0] hrdata;

  int          n_checks = 0;
  int          n_pass = 0;

  // reference model state, per responder
  logic [31:0] mmem [2][DEPTH];
  bit          rv [2];
  int          ridx [2];

  txn_t        q[$];
  logic [31:0] rd_log[$];
  logic        ok_log[$];

  always #5 clk = ~clk;

  assign htrans0 = sel ? 2'b00 : htrans;
  assign htrans2 = sel ? htrans : 2'b00;
  assign hready  = sel ? hready2  : hready0;
  assign hresp   = sel ? hresp2   : hresp0;
  assign hexokay = sel ? hexokay2 : hexokay0;
  assign hrdata  = sel ? hrdata2  : hrdata0;

  ahb_sram_excl_resp #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .haddr(haddr), .hwrite(hwrite), .htrans(htrans0), .hexcl(hexcl),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready0), .hresp(hresp0), .hexokay(hexokay0), .hrdata(hrdata0)
  );

  ahb_sram_excl_resp #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .haddr(haddr), .hwrite(hwrite), .htrans(htrans2), .hexcl(hexcl),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready2), .hresp(hresp2), .hexokay(hexokay2), .hrdata(hrdata2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int ws_of();
    return sel ? 2 : 0;
  endfunction

  function automatic bit err_of(input txn_t t);
    int nbytes;
    if (t.sz > 3'd2) return 1'b1;
    nbytes = 1 << t.sz;
    return ((t.addr % nbytes) != 0) || ((t.addr / 4) >= DEPTH);
  endfunction

  function automatic txn_t mk(input bit wr, input bit ex, input int sz, input int addr, input logic [31:0] wd);
    txn_t t;
    t.wr = wr; t.ex = ex; t.sz = 3'(sz); t.addr = 32'(addr); t.wdata = wd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int r, w, off, sz;
    r  = int'($urandom_range(0, 15));
    sz = (r == 0) ? 3 : r % 3;
    w  = int'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) w = DEPTH + int'($urandom_range(0, 3));
    off = int'($urandom_range(0, 3));
    if (sz <= 2 && $urandom_range(0, 7) != 0) off = off & ~((1 << sz) - 1);
    return mk(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), sz, w * 4 + off, $urandom);
  endfunction

  // Judge one completed data phase against the transfer-level rules and update the model
  task automatic complete(input txn_t t, input int waits);
    bit  err, commit;
    int  idx, lane, s;
    s   = sel ? 1 : 0;
    err = err_of(t);
    idx = int'(t.addr >> 2);
    chk("wait_cycles", 32'(waits), 32'(ws_of() + (err ? 1 : 0)));
    chk("hresp", {31'd0, hresp}, {31'd0, err});
    rd_log.push_back(hrdata);
    ok_log.push_back(hexokay);
    if (err) begin
      chk("err_rdata", hrdata, 32'd0);
      chk("err_exokay", {31'd0, hexokay}, 32'd0);
    end else if (!t.wr) begin
      chk("rdata", hrdata, mmem[s][idx]);
      chk("rd_exokay", {31'd0, hexokay}, {31'd0, EXCL && t.ex});
      if (EXCL && t.ex) begin
        rv[s]   = 1'b1;
        ridx[s] = idx;
      end
    end else begin
      commit = !EXCL || !t.ex || (rv[s] && ridx[s] == idx);
      chk("wr_exokay", {31'd0, hexokay}, {31'd0, EXCL && t.ex && commit});
      if (commit) begin
        for (int i = 0; i < (1 << t.sz); i++) begin
          lane = int'(t.addr[1:0]) + i;
          mmem[s][idx][8*lane +: 8] = t.wdata[8*lane +: 8];
        end
        if (rv[s] && ridx[s] == idx) rv[s] = 1'b0;
      end
    end
  endtask

  // Drive every queued transfer pipelined: a new address goes out in each cycle where hready is high
  task automatic run_queue();
    txn_t cur, nxt;
    bit   pend, nxt_pend, acc;
    int   waits, guard;
    pend  = 1'b0;
    waits = 0;
    guard = 0;
    while ((q.size() != 0 || pend) && guard < 5000) begin
      guard++;
      @(negedge clk);
      if (pend) begin
        if (!hready) begin
          chk("wait_hresp", {31'd0, hresp}, {31'd0, (waits >= ws_of()) && err_of(cur)});
          chk("wait_rdata", hrdata, 32'd0);
          waits++;
          if (waits > 20) begin
            chk("wait_bound", 32'(waits), 32'd20);
            pend = 1'b0;
          end
        end else begin
          complete(cur, waits);
          pend = 1'b0;
        end
      end
      nxt_pend = 1'b0;
      acc      = hready;
      if (hready) begin
        if (q.size() != 0) begin
          nxt    = q.pop_front();
          haddr  = nxt.addr;
          hwrite = nxt.wr;
          hsize  = nxt.sz;
          hexcl  = nxt.ex;
          htrans = 2'b10;
          nxt_pend = 1'b1;
        end else begin
          htrans = 2'b00;
        end
      end
      @(posedge clk);
      #1;
      if (acc && nxt_pend) begin
        cur    = nxt;
        pend   = 1'b1;
        waits  = 0;
        hwdata = nxt.wr ? nxt.wdata : $urandom;
      end
    end
    if (guard >= 5000) chk("queue_drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] old30;
    rv[0] = 1'b0; rv[1] = 1'b0; ridx[0] = 0; ridx[1] = 0;

    // reset values of both responders
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hready0", {31'd0, hready0}, 32'd1);
    chk("rst_hresp0", {31'd0, hresp0}, 32'd0);
    chk("rst_exokay0", {31'd0, hexokay0}, 32'd0);
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_hready2", {31'd0, hready2}, 32'd1);
    chk("rst_hresp2", {31'd0, hresp2}, 32'd0);
    chk("rst_exokay2", {31'd0, hexokay2}, 32'd0);
    chk("rst_rdata2", hrdata2, 32'd0);

    // give both memories known contents
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      for (int w = 0; w < DEPTH; w++) q.push_back(mk(1'b1, 1'b0, 2, w * 4, $urandom));
      run_queue();
    end

    // zero-wait write then pipelined read of the same word
    sel = 1'b0;
    rd_log.delete(); ok_log.delete();
    q.push_back(mk(1'b1, 1'b0, 2, 32'h10, 32'hDEADBEEF));
    q.push_back(mk(1'b0, 1'b0, 2, 32'h10, 32'h0));
    run_queue();
    chk("b2b_read", rd_log[1], 32'hDEADBEEF);

    // two-wait byte write into a cleared word
    sel = 1'b1;
    rd_log.delete(); ok_log.delete();
    q.push_back(mk(1'b1, 1'b0, 2, 32'h10, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 0, 32'h13, 32'hA5A5A5A5));
    q.push_back(mk(1'b0, 1'b0, 2, 32'h10, 32'h0));
    run_queue();
    chk("byte_merge", rd_log[2], 32'hA5000000);

    // error responses on both responders, followed by reads showing nothing changed
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      q.push_back(mk(1'b0, 1'b0, 2, 32'h2, 32'h0));
      q.push_back(mk(1'b1, 1'b0, 2, DEPTH * 4, 32'h12345678));
      q.push_back(mk(1'b1, 1'b0, 1, 32'h5, 32'h12345678));
      q.push_back(mk(1'b1, 1'b0, 3, 32'h8, 32'h12345678));
      q.push_back(mk(1'b0, 1'b0, 2, 32'h0, 32'h0));
      q.push_back(mk(1'b0, 1'b0, 2, 32'h4, 32'h0));
      run_queue();
    end

    // exclusive pair succeeds once, the repeat fails
    sel = 1'b0;
    rd_log.delete(); ok_log.delete();
    q.push_back(mk(1'b0, 1'b1, 2, 32'h20, 32'h0));
    q.push_back(mk(1'b1, 1'b1, 2, 32'h20, 32'h1));
    q.push_back(mk(1'b1, 1'b1, 2, 32'h20, 32'h2));
    q.push_back(mk(1'b0, 1'b0, 2, 32'h20, 32'h0));
    run_queue();
    chk("exA_rd_ok", {31'd0, ok_log[0]}, {31'd0, EXCL});
    chk("exA_wr_ok", {31'd0, ok_log[1]}, {31'd0, EXCL});
    chk("exA_wr2_ok", {31'd0, ok_log[2]}, 32'd0);
    chk("exA_mem", rd_log[3], EXCL ? 32'h1 : 32'h2);

    // plain write to the reserved word breaks the reservation
    rd_log.delete(); ok_log.delete();
    q.push_back(mk(1'b0, 1'b1, 2, 32'h20, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 2, 32'h20, 32'h7));
    q.push_back(mk(1'b1, 1'b1, 2, 32'h20, 32'h9));
    q.push_back(mk(1'b0, 1'b0, 2, 32'h20, 32'h0));
    run_queue();
    chk("exB_wr_ok", {31'd0, ok_log[2]}, 32'd0);
    chk("exB_mem", rd_log[3], EXCL ? 32'h7 : 32'h9);

    // randomised traffic on both responders
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      for (int n = 0; n < 150; n++) q.push_back(rand_txn());
      run_queue();
    end

    // reset in the middle of a waited write, with a reservation held
    sel = 1'b1;
    q.push_back(mk(1'b0, 1'b1, 2, 32'h30, 32'h0));
    run_queue();
    old30 = mmem[1][12];
    @(negedge clk);
    haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0; htrans = 2'b10;
    @(posedge clk);
    #1 hwdata = 32'h55;
    @(negedge clk);
    chk("midrst_wait", {31'd0, hready}, 32'd0);
    htrans = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_hready", {31'd0, hready}, 32'd1);
    chk("midrst_hresp", {31'd0, hresp}, 32'd0);
    chk("midrst_exokay", {31'd0, hexokay}, 32'd0);
    chk("midrst_rdata", hrdata, 32'd0);
    rv[0] = 1'b0; rv[1] = 1'b0;
    rd_log.delete(); ok_log.delete();
    q.push_back(mk(1'b1, 1'b1, 2, 32'h30, 32'h66));
    q.push_back(mk(1'b0, 1'b0, 2, 32'h30, 32'h0));
    run_queue();
    chk("midrst_resv", {31'd0, ok_log[0]}, 32'd0);
    chk("midrst_mem", rd_log[1], EXCL ? old30 : 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
